// File: rtl/param_wb_pkg.sv
// -----------------------------------------------------------------------------
// param_wb_pkg
// Shared types and constants for the parameter write-back drain stage and
// for any FPU stage that needs the FP32 non-finite test.
//   pwb_state_t       : write-back FSM state (IDLE, ISSUE, DONE)
//   WORDS_DEFAULT     : default depth of the captured result vector
//   FP32_EXP_MSB/LSB  : bit range of the FP32 biased exponent
//   FP32_EXP_ALLONES  : exponent pattern shared by NaN and +/-Inf
// -----------------------------------------------------------------------------
package param_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } pwb_state_t;

  localparam int WORDS_DEFAULT = 32;

  localparam int FP32_EXP_MSB = 30;
  localparam int FP32_EXP_LSB = 23;

  localparam logic [FP32_EXP_MSB-FP32_EXP_LSB:0] FP32_EXP_ALLONES = 8'hFF;

endpackage

// File: rtl/param_writeback_if.sv
// -----------------------------------------------------------------------------
// param_writeback_if
// Single-outstanding memory write port driven by the write-back stage.
//   mem_req   : write request valid (master -> slave)
//   mem_we    : write enable, always equal to mem_req (master -> slave)
//   mem_addr  : word address (master -> slave)
//   mem_wdata : write data (master -> slave)
//   mem_ack   : write accepted (slave -> master)
//
// Handshake: a write transfers on a rising clock edge where mem_req and
// mem_ack are both high. Once mem_req rises, the master holds mem_req,
// mem_addr and mem_wdata stable until that edge. mem_ack while mem_req is
// low carries no meaning and is ignored. The master may not withdraw a
// request; the slave may hold mem_ack low for any number of cycles.
// -----------------------------------------------------------------------------
interface param_writeback_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );

endinterface

// File: rtl/fp32_is_nonfinite.sv
// -----------------------------------------------------------------------------
// fp32_is_nonfinite
// Flags an FP32 word as non-finite (NaN or +/-Inf): the biased exponent is
// all ones, regardless of sign and mantissa. Purely combinational.
//   word      : in  DATA_W  FP32 value
//   nonfinite : out 1       1 when the exponent field is all ones
// -----------------------------------------------------------------------------
module fp32_is_nonfinite
  import param_wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  output logic              nonfinite
);

  assign nonfinite = (word[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALLONES);

  // Sign and mantissa do not affect the classification.
  logic unused_bits;
  assign unused_bits = ^{word[DATA_W-1:FP32_EXP_MSB+1], word[FP32_EXP_LSB-1:0]};

endmodule

// File: rtl/param_writeback.sv
// -----------------------------------------------------------------------------
// param_writeback
// Drain stage behind the parameter-update FPU. On an accepted go it snapshots
// the updater's result vector, base address and (clamped) length, then writes
// words 0..len-1 to consecutive word addresses over a single-outstanding
// req/ack write port. done pulses for one cycle after the last write is
// accepted; nonfinite_cnt reports how many written words were NaN/Inf.
//
// Ports:
//   clk           : in   system clock, rising edge
//   rst_l         : in   synchronous reset, active HIGH (legacy name)
//   go            : in   start pulse, only honoured in IDLE
//   base_addr     : in   word address of result word 0
//   len           : in   words to write, clamped to WORDS
//   r_in          : in   packed result vector, word i at [i*DATA_W +: DATA_W]
//   busy          : out  high while a transfer is in ISSUE or DONE
//   done          : out  one-cycle completion pulse
//   nonfinite_cnt : out  non-finite words written; held until next go
//   mem           : master side of the write port (param_writeback_if)
//   state_dbg     : out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module param_writeback
  import param_wb_pkg::*;
#(
  parameter  int WORDS  = WORDS_DEFAULT,
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int LEN_W  = $clog2(WORDS) + 1,
  localparam int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    go,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LEN_W-1:0]        len,
  input  logic [WORDS*DATA_W-1:0] r_in,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_W-1:0]        nonfinite_cnt,
  param_writeback_if.master       mem,
  output pwb_state_t              state_dbg
);

  pwb_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] buf_q [WORDS];
  logic              req_q;

  logic [LEN_W-1:0]  len_clamp;
  logic [DATA_W-1:0] cur_word;
  logic              cur_nonfinite;
  logic              last_word;

  // Lengths above the buffer depth write the whole buffer and no more.
  assign len_clamp = (len > LEN_W'(WORDS)) ? LEN_W'(WORDS) : len;

  assign cur_word = buf_q[idx];

  // In ISSUE len_q is at least 1, so len_q-1 never underflows when used.
  assign last_word = ({1'b0, idx} == (len_q - LEN_W'(1)));

  fp32_is_nonfinite #(
    .DATA_W (DATA_W)
  ) u_nonfinite (
    .word      (cur_word),
    .nonfinite (cur_nonfinite)
  );

  // Address and data come straight from registered state; they are gated to
  // zero whenever no request is outstanding so the bus reads as idle.
  // Address arithmetic wraps modulo 2^ADDR_W.
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = req_q;
  assign mem.mem_addr  = req_q ? (base_q + ADDR_W'(idx)) : '0;
  assign mem.mem_wdata = req_q ? cur_word : '0;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst_l) begin
      state         <= IDLE;
      idx           <= '0;
      len_q         <= '0;
      base_q        <= '0;
      req_q         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      nonfinite_cnt <= '0;
      for (int i = 0; i < WORDS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (go) begin
            for (int i = 0; i < WORDS; i++) begin
              buf_q[i] <= r_in[i*DATA_W +: DATA_W];
            end
            base_q        <= base_addr;
            len_q         <= len_clamp;
            idx           <= '0;
            nonfinite_cnt <= '0;
            busy          <= 1'b1;
            if (len_clamp == '0) begin
              // Nothing to write: complete without touching the bus.
              state <= DONE;
              done  <= 1'b1;
              req_q <= 1'b0;
            end else begin
              state <= ISSUE;
              req_q <= 1'b1;
            end
          end
        end

        ISSUE: begin
          // req_q is always high here, so mem_ack alone marks acceptance.
          if (mem.mem_ack) begin
            nonfinite_cnt <= nonfinite_cnt + LEN_W'(cur_nonfinite);
            if (last_word) begin
              state <= DONE;
              req_q <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          req_q <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/param_writeback.md
# param_writeback

Drain stage directly downstream of the parameter-update FPU block. On `go` it captures the updater's 32-word FP32 result vector, then writes the first `len` words to consecutive word addresses through a single-outstanding req/ack memory write port. It pulses `done` when the last write is acknowledged, and reports how many written words were non-finite (NaN/Inf) for training-health monitoring.

## Interface
Parameters:
- `WORDS`, 32, depth of the captured result vector.
- `DATA_W`, 32, word width (FP32).
- `ADDR_W`, 32, word-address width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_l`  in  1  reset, synchronous, active-high (name retained from codebase).
- `go`  in  1  start pulse; sampled only in IDLE.
- `base_addr`  in  ADDR_W  word address of result word 0; captured on accepted `go`.
- `len`  in  $clog2(WORDS)+1  number of words to write; captured on accepted `go`.
- `r_in`  in  WORDS×DATA_W  packed result vector from updater; captured on accepted `go`.
- `busy`  out  1  high in ISSUE and DONE.
- `done`  out  1  single-cycle completion pulse.
- `nonfinite_cnt`  out  $clog2(WORDS)+1  count of written words with exponent == 8'hFF; held after `done` until next accepted `go`.
- `mem_req`  out  1  write request valid.
- `mem_we`  out  1  equals `mem_req`; this block only writes.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_ack`  in  1  write accepted this cycle when `mem_req` is high.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE:
  - `go`=1 → capture `r_in`, `base_addr`, and `min(len, WORDS)`; clear `idx` and `nonfinite_cnt`.
  - Next state is ISSUE, or DONE if the clamped length is 0.
- ISSUE:
  - `mem_req`=1, `mem_addr`=`base+idx` (mod 2^ADDR_W, wraps silently), `mem_wdata`=`buf[idx]`.
  - Request, address and data are held stable until `mem_ack`.
  - On ack: `nonfinite_cnt` += (exponent of `buf[idx]` all ones); `idx`++.
  - If `idx` == len-1 at the ack → DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `go` outside IDLE is ignored. No queueing, and captured data is not disturbed.
- `mem_ack` while `mem_req`=0 is ignored.
- `r_in` may change freely after the capture cycle. The updater may start its next batch immediately.
- Reset (any state, including mid-transfer with `mem_req` high):
  - Next cycle: state IDLE.
  - Outputs `busy`=0, `done`=0, `mem_req`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `nonfinite_cnt`=0.
  - Internal `idx` and buffer are cleared.
  - Reset dominates a coincident `go` or `mem_ack`.

## Timing
- Accepted `go` at cycle t → `mem_req` high at t+1.
- With `mem_ack` tied high: one word per cycle, `done` at t+len+1.
- With len=0: `done` at t+1 and no `mem_req` at all.
- Each cycle of `mem_ack` low adds one cycle of latency.
- Earliest next accepted `go` is the cycle after `done` (t+len+2).
- Outputs are registered, except `mem_addr`/`mem_wdata`, which may be driven combinationally from `idx` and registered state; no input-to-output combinational path.

## Structure
- Package `param_wb_pkg` holds:
  - the state enum `pwb_state_t` {IDLE, ISSUE, DONE};
  - `WORDS_DEFAULT`, `FP32_EXP_MSB`/`LSB`, and the `FP32_EXP_ALLONES` constant.
- `fp32_is_nonfinite` is a sub-module (DATA_W in, 1-bit out), reusable by other FPU stages.
- Everything else lives in one `param_writeback` module: capture buffer, `idx` counter, FSM, counter.

## Test plan
- **Basic burst:**
  - Stimulus: `base_addr`=32'h100, `len`=4, `r_in[i]`=32'h3F80_0000+i, `mem_ack`=1.
  - Required: writes to 0x100–0x103 with matching data on cycles t+1..t+4; `done` at t+5; `nonfinite_cnt`=0.
- **Backpressure:**
  - Stimulus: `len`=3, `mem_ack` low for 2 cycles on every word.
  - Required: addr/data stable while waiting; exactly 3 acked writes; `done` at t+10.
- **Non-finite count:**
  - Stimulus: words {7F80_0000, 7FC0_0001, FF80_0000, 3F80_0000}, `len`=4.
  - Required: `nonfinite_cnt`=3 after `done`.
- **Edge lengths:**
  - `len`=0 → `done` at t+1, no request.
  - `len`=40 → clamped to 32 writes.
  - `base_addr`=32'hFFFF_FFFE, `len`=3 → addresses FFFF_FFFE, FFFF_FFFF, 0000_0000.
- **Busy go / data change:**
  - Stimulus: second `go` with different `r_in` during ISSUE; `r_in` also changed right after capture.
  - Required: original data written; second `go` dropped; only one `done`.
- **Reset mid-transfer:**
  - Stimulus: assert `rst_l` while `mem_req`=1 at `idx`=2 of 8.
  - Required: `mem_req`=0 and all outputs zero the next cycle; no `done`; a fresh `go` afterwards runs a full correct burst.
